// File: rtl/lm_sm_sequencer_pkg.sv
// Shared constants and types for the LM/SM multi-beat sequencer.
package lm_sm_sequencer_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_NREG   = 8;
  localparam int unsigned DEF_IDX_W  = 3;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_t;

  function automatic logic is_lmsm(input logic [3:0] opc);
    return (opc == OP_LM) || (opc == OP_SM);
  endfunction

endpackage

// File: rtl/lm_sm_sequencer_if.sv
// Upstream/memory-stage bundle for the LM/SM sequencer.
// LMSM_BASE_WB_EN adds the base write-back pair.
interface lm_sm_if
  import lm_sm_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned IDX_W  = DEF_IDX_W
);
  logic              start;
  logic              start_ready;
  logic [15:0]       ir;
  logic [ADDR_W-1:0] base_addr;
  logic              hold;
  logic              flush;
  logic              stall_up;
  logic              beat_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [IDX_W-1:0]  reg_idx;
  logic              mem_write;
  logic              rf_write;
  logic              done;
`ifdef LMSM_BASE_WB_EN
  logic              base_wb_valid;
  logic [ADDR_W-1:0] base_wb_data;

  modport master (
    output start, ir, base_addr, hold, flush,
    input  start_ready, stall_up, beat_valid, mem_addr, reg_idx,
           mem_write, rf_write, done, base_wb_valid, base_wb_data
  );
  modport slave (
    input  start, ir, base_addr, hold, flush,
    output start_ready, stall_up, beat_valid, mem_addr, reg_idx,
           mem_write, rf_write, done, base_wb_valid, base_wb_data
  );
`else
  modport master (
    output start, ir, base_addr, hold, flush,
    input  start_ready, stall_up, beat_valid, mem_addr, reg_idx,
           mem_write, rf_write, done
  );
  modport slave (
    input  start, ir, base_addr, hold, flush,
    output start_ready, stall_up, beat_valid, mem_addr, reg_idx,
           mem_write, rf_write, done
  );
`endif
endinterface

// File: rtl/lm_sm_sequencer_lsb_pri_enc8.sv
// Lowest-set-bit priority encoder: any flag, binary index and one-hot of that bit.
module lsb_pri_enc8 (
  input  logic [7:0] mask,
  output logic       any,
  output logic [2:0] idx,
  output logic [7:0] onehot
);

  always_comb begin
    any    = |mask;
    onehot = mask & (~mask + 8'd1);
    idx    = '0;
    // Scan high to low so the lowest set bit is the last (winning) write.
    for (int unsigned i = 0; i < 8; i++) begin
      if (mask[7-i]) idx = 3'(7 - i);
    end
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM expander: one memory beat per set IR[7:0] bit, lowest register first.
// LMSM_BASE_WB_EN adds base_wb_valid/base_wb_data on the done cycle.
module lm_sm_sequencer
  import lm_sm_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NREG   = DEF_NREG,
  parameter int unsigned IDX_W  = DEF_IDX_W
) (
  input  logic   clk,
  input  logic   rst_n,
  lm_sm_if.slave bus
);

  state_t            state;
  logic [NREG-1:0]   mask;
  logic [ADDR_W-1:0] addr;
  logic              op;

  logic              mask_any;
  logic [IDX_W-1:0]  low_idx;
  logic [NREG-1:0]   low_bit;
  logic              ready;
  logic              accept;
  logic              last;
  logic              unused_ir;

  lsb_pri_enc8 u_enc (
    .mask   (mask),
    .any    (mask_any),
    .idx    (low_idx),
    .onehot (low_bit)
  );

  assign unused_ir = ^bus.ir[11:8];
  assign ready     = rst_n && (state == ST_IDLE) && !bus.flush;
  assign accept    = bus.start && ready && is_lmsm(bus.ir[15:12]);
  assign last      = mask_any && ((mask & ~low_bit) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      mask  <= '0;
      addr  <= '0;
      op    <= 1'b0;
    end else if (bus.flush) begin
      state <= ST_IDLE;
      mask  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            mask  <= bus.ir[NREG-1:0];
            addr  <= bus.base_addr;
            op    <= bus.ir[12];
            state <= (bus.ir[NREG-1:0] != '0) ? ST_RUN : ST_FIN;
          end
        end
        ST_RUN: begin
          if (!bus.hold) begin
            mask <= mask & ~low_bit;
            addr <= addr + ADDR_W'(1);
            if (last) state <= ST_IDLE;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; flush zeroes everything in its own cycle.
  always_comb begin
    bus.start_ready = ready;
    bus.stall_up    = 1'b0;
    bus.beat_valid  = 1'b0;
    bus.mem_addr    = '0;
    bus.reg_idx     = '0;
    bus.mem_write   = 1'b0;
    bus.rf_write    = 1'b0;
    bus.done        = 1'b0;
`ifdef LMSM_BASE_WB_EN
    bus.base_wb_valid = 1'b0;
    bus.base_wb_data  = '0;
`endif
    if (!bus.flush) begin
      unique case (state)
        ST_IDLE: bus.stall_up = accept;
        ST_RUN: begin
          bus.mem_addr = addr;
          bus.reg_idx  = low_idx;
          bus.stall_up = bus.hold || !last;
          if (!bus.hold) begin
            bus.beat_valid = 1'b1;
            bus.mem_write  = op;
            bus.rf_write   = ~op;
            bus.done       = last;
`ifdef LMSM_BASE_WB_EN
            bus.base_wb_valid = last;
            bus.base_wb_data  = last ? addr + ADDR_W'(1) : '0;
`endif
          end
        end
        ST_FIN: begin
          bus.done = 1'b1;
`ifdef LMSM_BASE_WB_EN
          bus.base_wb_valid = 1'b1;
          bus.base_wb_data  = addr;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: directed scenarios plus randomized transactions.
module tb_lm_sm_sequencer;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned IDX_W  = 3;

  typedef logic [41:0] ov_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  lm_sm_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

  lm_sm_sequencer #(.ADDR_W(ADDR_W), .NREG(8), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected output vector: {start_ready, stall_up, beat_valid, mem_write, rf_write, done, addr, idx, wb_valid, wb_data}
  function automatic ov_t mk(input logic sr, input logic st, input logic bv, input logic mw,
                             input logic rw, input logic dn, input logic [15:0] a,
                             input logic [2:0] i, input logic wv, input logic [15:0] wd);
`ifndef LMSM_BASE_WB_EN
    wv = 1'b0;
    wd = '0;
`endif
    return {sr, st, bv, mw, rw, dn, a, i, wv, wd};
  endfunction

  function automatic ov_t obs();
    logic        wv;
    logic [15:0] wd;
    wv = 1'b0;
    wd = '0;
`ifdef LMSM_BASE_WB_EN
    wv = bus.base_wb_valid;
    wd = bus.base_wb_data;
`endif
    return {bus.start_ready, bus.stall_up, bus.beat_valid, bus.mem_write, bus.rf_write,
            bus.done, bus.mem_addr, bus.reg_idx, wv, wd};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One LM/SM from acceptance to completion against a list of expected beats.
  // flush_beat: 1-based RUN beat that gets flushed (0 = none); hold_first forces hold on the first RUN cycle.
  task automatic run_txn(input logic sm, input logic [7:0] m, input logic [15:0] base,
                         input int unsigned hold_pct, input int unsigned flush_beat,
                         input logic hold_first, input string tag);
    int unsigned idxq[$];
    logic [15:0] addrq[$];
    int unsigned n, k, cyc;
    logic        h, f, lst;
    ov_t         o, e;
    logic [3:0]  opc;
    logic [3:0]  mid;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        addrq.push_back(base + 16'(idxq.size()));
        idxq.push_back(i);
      end
    end
    n   = idxq.size();
    opc = sm ? 4'b0111 : 4'b0110;
    mid = 4'($urandom);
    bus.start = 1'b1; bus.ir = {opc, mid, m}; bus.base_addr = base;
    bus.hold = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    o = obs(); e = mk(1, 1, 0, 0, 0, 0, '0, '0, 0, '0);
    checks++;
    if (o !== e) begin fails++; $display("FAIL %s accept: got %h expected %h", tag, o, e); end
    next_cycle();
    if (n == 0) begin
      bus.start = 1'($urandom); bus.ir = 16'($urandom);
      @(negedge clk);
      o = obs(); e = mk(0, 0, 0, 0, 0, 1, '0, '0, 1, base);
      checks++;
      if (o !== e) begin fails++; $display("FAIL %s empty_done: got %h expected %h", tag, o, e); end
      next_cycle();
    end else begin
      k = 0; cyc = 0;
      while (k < n && cyc < 64) begin
        h = ($urandom_range(99) < hold_pct) || (hold_first && cyc == 0);
        f = (flush_beat == k + 1) && !h;
        bus.hold = h; bus.flush = f;
        bus.start = 1'($urandom); bus.ir = 16'($urandom); bus.base_addr = 16'($urandom);
        @(negedge clk);
        lst = (k == n - 1);
        if (f)      e = mk(0, 0, 0, 0, 0, 0, '0, '0, 0, '0);
        else if (h) e = mk(0, 1, 0, 0, 0, 0, addrq[k], 3'(idxq[k]), 0, '0);
        else        e = mk(0, !lst, 1, sm, !sm, lst, addrq[k], 3'(idxq[k]), lst,
                           lst ? base + 16'(n) : 16'h0);
        o = obs();
        checks++;
        if (o !== e) begin
          fails++;
          $display("FAIL %s beat%0d: got %h expected %h", tag, k, o, e);
        end
        next_cycle();
        cyc++;
        if (f) break;
        if (!h) k++;
      end
      if (cyc >= 64) begin
        fails++;
        $display("FAIL %s timeout: got %0d beats expected %0d", tag, k, n);
      end
    end
    bus.start = 1'b0; bus.hold = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    ov_t o, e;
    bus.start = 1'b1; bus.ir = 16'h60FF; bus.base_addr = 16'h1234;
    bus.hold = 1'b0; bus.flush = 1'b0;
    #3;
    o = obs(); e = mk(0, 0, 0, 0, 0, 0, '0, '0, 0, '0);
    checks++;
    if (o !== e) begin fails++; $display("FAIL reset_outputs: got %h expected %h", o, e); end
    bus.start = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    o = obs(); e = mk(1, 0, 0, 0, 0, 0, '0, '0, 0, '0);
    checks++;
    if (o !== e) begin fails++; $display("FAIL reset_idle: got %h expected %h", o, e); end
    next_cycle();
  endtask

  task automatic test_lm_basic();
    run_txn(1'b0, 8'b1010_0010, 16'h0040, 0, 0, 1'b0, "lm_basic");
  endtask

  task automatic test_sm_wrap();
    run_txn(1'b1, 8'hFF, 16'hFFFE, 0, 0, 1'b0, "sm_wrap");
  endtask

  task automatic test_empty();
    run_txn(1'b0, 8'h00, 16'h0BAD, 0, 0, 1'b0, "lm_empty");
  endtask

  task automatic test_hold();
    run_txn(1'b1, 8'h0C, 16'h2000, 0, 0, 1'b1, "sm_hold");
  endtask

  task automatic test_flush();
    run_txn(1'b0, 8'h07, 16'h0100, 0, 2, 1'b0, "lm_flush");
    run_txn(1'b1, 8'h30, 16'h0200, 0, 0, 1'b0, "sm_after_flush");
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 8'h81, 16'h7FFF, 0, 0, 1'b0, "b2b_a");
    run_txn(1'b0, 8'h00, 16'h0010, 0, 0, 1'b0, "b2b_b");
    run_txn(1'b0, 8'h40, 16'h0020, 0, 0, 1'b0, "b2b_c");
  endtask

  task automatic test_bad_opcode();
    ov_t o, e;
    logic [3:0] opc;
    for (int i = 0; i < 4; i++) begin
      do opc = 4'($urandom); while (opc == 4'b0110 || opc == 4'b0111);
      bus.start = 1'b1; bus.ir = {opc, 4'h0, 8'hFF}; bus.base_addr = 16'($urandom);
      @(negedge clk);
      o = obs(); e = mk(1, 0, 0, 0, 0, 0, '0, '0, 0, '0);
      checks++;
      if (o !== e) begin fails++; $display("FAIL bad_opcode %h: got %h expected %h", opc, o, e); end
      next_cycle();
    end
    bus.start = 1'b0;
  endtask

  task automatic test_midrun_reset();
    ov_t o, e;
    bus.start = 1'b1; bus.ir = 16'h60FF; bus.base_addr = 16'h0300;
    next_cycle();
    bus.start = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #1;
    o = obs(); e = mk(0, 0, 0, 0, 0, 0, '0, '0, 0, '0);
    checks++;
    if (o !== e) begin fails++; $display("FAIL midrun_reset: got %h expected %h", o, e); end
    next_cycle();
    rst_n = 1'b1;
    bus.start = 1'b1; bus.ir = 16'h00FF;
    @(negedge clk);
    o = obs(); e = mk(1, 0, 0, 0, 0, 0, '0, '0, 0, '0);
    checks++;
    if (o !== e) begin fails++; $display("FAIL add_after_reset: got %h expected %h", o, e); end
    next_cycle();
    bus.start = 1'b0;
    @(negedge clk);
    o = obs();
    checks++;
    if (o !== e) begin fails++; $display("FAIL idle_after_add: got %h expected %h", o, e); end
    next_cycle();
  endtask

  task automatic test_random();
    logic [7:0]  m;
    int unsigned fb;
    for (int t = 0; t < 30; t++) begin
      m  = ($urandom_range(5) == 0) ? 8'h00 : 8'($urandom);
      fb = ($urandom_range(5) == 0) ? $urandom_range(1, 3) : 0;
      run_txn(1'($urandom), m, 16'($urandom), 25, fb, 1'b0, "random");
      if ($urandom_range(2) == 0) next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_lm_basic();
    test_sm_wrap();
    test_empty();
    test_hold();
    test_flush();
    test_back_to_back();
    test_bad_opcode();
    test_midrun_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
